alu_writeback: RTL and testbench
================================

Name: alu_writeback

Overview:
- Consumer end of the ALU result handshake; sits between the ALU and the register file.
- Takes the ALU's level `readyOut` and its result bundle (data, flags, write enable, destination), and commits results to a 16x32 register file and the CPSR flags.
- Returns the two-phase toggle trigger that releases the ALU for its next operation.
- Clocked block bridging the self-timed ALU; `readyIn` is treated as asynchronous.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the `readyIn` synchronizer (min 2)
TIMEOUT, 255, cycles allowed in WAIT_LOW before `timeoutErr` sets
NUM_REGS, 16, register file depth (index width 4)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
dataIn1  input  32  ALU primary result
dataIn2  input  32  ALU secondary result
cpsrIn  input  32  ALU flags, [31:28] = N,Z,C,V
srcDstIn  input  32  [3:0] Rd, [7:4] Rd2, [8] write2 enable; other bits ignored
wIn  input  1  1 = write dataIn1 to Rd
readyIn  input  1  ALU result-valid level (asynchronous)
triggerOut  output  1  two-phase acknowledge; every toggle releases the ALU once
rdAddr1  input  4  read port 1 index
rdData1  output  32  combinational read of reg[rdAddr1]
rdAddr2  input  4  read port 2 index
rdData2  output  32  combinational read of reg[rdAddr2]
cpsrOut  output  32  committed CPSR; [27:0] constant 0
pcWrite  output  1  one-cycle pulse when r15 is written
busy  output  1  high in WRITE1, WRITE2, ACK
timeoutErr  output  1  sticky; set on handshake timeout

Behaviour:
Reset (`reset` low, asynchronous):
- State = KICK.
- `triggerOut`, `cpsrOut`, `pcWrite`, `busy`, `timeoutErr` = 0.
- All registers and the capture latches = 0; synchronizer cleared.
- Reset mid-transaction discards any uncommitted write; no partial commit.

Synchronizer: `readyIn` passes through SYNC_STAGES flops to give `rdyS`. The FSM uses only `rdyS`.

FSM:
- KICK: toggle `triggerOut` on the first edge after reset release (starts the ALU) -> WAIT_LOW.
- WAIT_LOW: wait for `rdyS` == 0 -> WAIT_HIGH. Counter increments each cycle here; reaching TIMEOUT sets `timeoutErr`. State does not change on timeout. The counter clears on leaving the state.
- WAIT_HIGH: on `rdyS` == 1, capture `dataIn1`, `dataIn2`, `cpsrIn[31:28]`, `srcDstIn[8:0]`, `wIn` -> WRITE1. No timeout in this state; the ALU may stall indefinitely.
- WRITE1:
  - If captured w, reg[Rd] <= data1.
  - `cpsrOut[31:28]` <= captured flags, unconditionally; the ALU holds its flags when S=0.
  - -> WRITE2 if write2 is set, else -> ACK.
- WRITE2: reg[Rd2] <= data2 -> ACK. If Rd2 == Rd, the WRITE2 value remains.
- ACK: toggle `triggerOut` -> WAIT_LOW.

Timing and read ports:
- Latency: let edge k be the first edge that samples `readyIn` high. `triggerOut` toggles at edge k+SYNC_STAGES+2 (no write2) or k+SYNC_STAGES+3 (write2).
- `pcWrite` is high for the cycle following any edge that writes index 15. A dual write to 15 gives a 2-cycle pulse.
- Read ports have no bypass; a write is visible on `rdData` after the writing edge.
- A `readyIn` glitch shorter than the synchronizer window may be missed. The ALU holds `readyIn` until it sees a toggle, so this is harmless.
- `readyIn` high again before the toggle is ignored; the FSM still requires a low phase (WAIT_LOW) before each capture.
- Inputs change only while `readyIn` is low; values sampled at capture are final.

Test Plan:
- Release `reset` -> `triggerOut` goes 0->1 on the first edge; `rdData1` = 0 for every index; `cpsrOut` = 0; `busy` = 0.
- `readyIn` low for 3 cycles then high; `dataIn1`=0xDEADBEEF, Rd=3, `wIn`=1, `cpsrIn`=0x60000000 -> r3=0xDEADBEEF; `cpsrOut`=0x60000000; `triggerOut` toggles at k+4.
- `wIn`=0, `cpsrIn`=0x80000000 (cmp) -> registers unchanged; `cpsrOut`=0x80000000; `triggerOut` still toggles.
- write2=1, Rd=1, Rd2=1, `dataIn1`=0x11, `dataIn2`=0x22 -> r1=0x22; toggle at k+5; `busy` high for 3 cycles.
- Rd=15, `wIn`=1, `dataIn1`=0x100 -> `pcWrite` 1-cycle pulse; r15=0x100.
- Hold `readyIn` high 300 cycles after a toggle -> `timeoutErr`=1, no capture. Then assert `reset` during WRITE2 of the next transaction -> all registers 0, `timeoutErr`=0, and KICK toggle after release.

Source files
------------

// File: rtl/alu_writeback_if.sv
// Result handshake between the self-timed ALU and the writeback stage: level ready from the ALU,
// two-phase toggle acknowledge back to it.
interface alu_writeback_if;
   logic [31:0] dataIn1;
   logic [31:0] dataIn2;
   logic [31:0] cpsrIn;
   logic [31:0] srcDstIn;
   logic        wIn;
   logic        readyIn;
   logic        triggerOut;

   modport master (
      output dataIn1, dataIn2, cpsrIn, srcDstIn, wIn, readyIn,
      input  triggerOut
   );

   modport slave (
      input  dataIn1, dataIn2, cpsrIn, srcDstIn, wIn, readyIn,
      output triggerOut
   );
endinterface

// File: rtl/alu_writeback.sv
// ALU writeback: synchronizes the ALU's asynchronous ready level, commits results to a 16x32
// register file and the CPSR flags, and answers each result with one toggle of triggerOut.
module alu_writeback #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT     = 255,
   parameter int unsigned NUM_REGS    = 16
) (
   input  logic           clk,
   input  logic           reset,
   alu_writeback_if.slave alu,
   input  logic [3:0]     rdAddr1,
   output logic [31:0]    rdData1,
   input  logic [3:0]     rdAddr2,
   output logic [31:0]    rdData2,
   output logic [31:0]    cpsrOut,
   output logic           pcWrite,
   output logic           busy,
   output logic           timeoutErr
);
   localparam logic [2:0] stKick     = 3'd0;
   localparam logic [2:0] stWaitLow  = 3'd1;
   localparam logic [2:0] stWaitHigh = 3'd2;
   localparam logic [2:0] stWrite1   = 3'd3;
   localparam logic [2:0] stWrite2   = 3'd4;
   localparam logic [2:0] stAck      = 3'd5;

   localparam int unsigned CntW  = $clog2(TIMEOUT + 1);
   localparam logic [3:0]  PcIdx = 4'd15;

   logic [2:0]             state;
   logic [SYNC_STAGES-1:0] syncQ;
   logic                   rdyS;
   logic [CntW-1:0]        waitCnt;
   logic                   trigger;
   logic [31:0]            regs [NUM_REGS];
   logic [31:0]            capData1;
   logic [31:0]            capData2;
   logic [3:0]             capFlags;
   logic [3:0]             capRd;
   logic [3:0]             capRd2;
   logic                   capW;
   logic                   capW2;
   logic [3:0]             cpsrFlags;
   logic                   unusedBits;

   assign rdyS           = syncQ[SYNC_STAGES-1];
   assign alu.triggerOut = trigger;
   assign rdData1        = regs[rdAddr1];
   assign rdData2        = regs[rdAddr2];
   assign cpsrOut        = {cpsrFlags, 28'h0};
   assign busy           = (state == stWrite1) || (state == stWrite2) || (state == stAck);
   assign unusedBits     = ^{alu.srcDstIn[31:9], alu.cpsrIn[27:0]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= stKick;
         syncQ      <= '0;
         waitCnt    <= '0;
         trigger    <= 1'b0;
         regs       <= '{default: '0};
         capData1   <= '0;
         capData2   <= '0;
         capFlags   <= '0;
         capRd      <= '0;
         capRd2     <= '0;
         capW       <= 1'b0;
         capW2      <= 1'b0;
         cpsrFlags  <= '0;
         pcWrite    <= 1'b0;
         timeoutErr <= 1'b0;
      end else begin
         syncQ   <= {syncQ[SYNC_STAGES-2:0], alu.readyIn};
         pcWrite <= 1'b0;
         case (state)
            stKick: begin
               trigger <= ~trigger;
               state   <= stWaitLow;
            end
            stWaitLow: begin
               if (!rdyS) begin
                  waitCnt <= '0;
                  state   <= stWaitHigh;
               end else if (waitCnt != CntW'(TIMEOUT)) begin
                  // Counter saturates at TIMEOUT; the error flag stays until reset.
                  waitCnt <= waitCnt + CntW'(1);
                  if (waitCnt == CntW'(TIMEOUT - 1)) timeoutErr <= 1'b1;
               end
            end
            stWaitHigh: begin
               if (rdyS) begin
                  capData1 <= alu.dataIn1;
                  capData2 <= alu.dataIn2;
                  capFlags <= alu.cpsrIn[31:28];
                  capRd    <= alu.srcDstIn[3:0];
                  capRd2   <= alu.srcDstIn[7:4];
                  capW2    <= alu.srcDstIn[8];
                  capW     <= alu.wIn;
                  state    <= stWrite1;
               end
            end
            stWrite1: begin
               if (capW) regs[capRd] <= capData1;
               // Flags always commit: the ALU presents unchanged flags when S is clear.
               cpsrFlags <= capFlags;
               pcWrite   <= capW && (capRd == PcIdx);
               state     <= capW2 ? stWrite2 : stAck;
            end
            stWrite2: begin
               regs[capRd2] <= capData2;
               pcWrite      <= (capRd2 == PcIdx);
               state        <= stAck;
            end
            stAck: begin
               trigger <= ~trigger;
               state   <= stWaitLow;
            end
            default: state <= stKick;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_writeback.sv
// Randomized bench for alu_writeback: an ALU-side driver plus a register-file/CPSR model built
// from the handshake rules (latency, busy, pcWrite pulses, timeout, reset behaviour).
module tb_alu_writeback;
   localparam int SyncStages = 2;

   logic        clk;
   logic        reset;
   logic [3:0]  rdAddr1;
   logic [31:0] rdData1;
   logic [3:0]  rdAddr2;
   logic [31:0] rdData2;
   logic [31:0] cpsrOut;
   logic        pcWrite;
   logic        busy;
   logic        timeoutErr;

   alu_writeback_if aluIf ();

   alu_writeback #(
      .SYNC_STAGES(SyncStages),
      .TIMEOUT    (255),
      .NUM_REGS   (16)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .alu       (aluIf),
      .rdAddr1   (rdAddr1),
      .rdData1   (rdData1),
      .rdAddr2   (rdAddr2),
      .rdData2   (rdData2),
      .cpsrOut   (cpsrOut),
      .pcWrite   (pcWrite),
      .busy      (busy),
      .timeoutErr(timeoutErr)
   );

   int          errors = 0;
   int          checks = 0;
   logic [31:0] model [16];
   logic [3:0]  modelFlags;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic run_txn(input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] cpsr,
                          input logic [31:0] sd, input logic w, input string tag);
      int         n;
      int         busyCnt;
      int         pcCnt;
      int         expN;
      int         expPc;
      logic       trig0;
      logic       toggled;
      logic [3:0] rd;
      logic [3:0] rd2;
      logic       w2;
      rd  = sd[3:0];
      rd2 = sd[7:4];
      w2  = sd[8];
      @(negedge clk);
      aluIf.readyIn  = 1'b0;
      aluIf.dataIn1  = d1;
      aluIf.dataIn2  = d2;
      aluIf.cpsrIn   = cpsr;
      aluIf.srcDstIn = sd;
      aluIf.wIn      = w;
      repeat (3) @(negedge clk);
      trig0         = aluIf.triggerOut;
      aluIf.readyIn = 1'b1;
      n = 0; busyCnt = 0; pcCnt = 0; toggled = 1'b0;
      while (!toggled && n < 40) begin
         @(negedge clk);
         n++;
         if (busy) busyCnt++;
         if (pcWrite) pcCnt++;
         if (aluIf.triggerOut !== trig0) toggled = 1'b1;
      end
      // n counts edges with the first high-sampling edge as 1
      expN  = SyncStages + (w2 ? 3 : 2) + 1;
      expPc = ((w && rd == 4'd15) ? 1 : 0) + ((w2 && rd2 == 4'd15) ? 1 : 0);
      if (w) model[rd] = d1;
      if (w2) model[rd2] = d2;
      modelFlags = cpsr[31:28];

      checks++;
      if (!toggled || n !== expN) begin
         errors++;
         $display("FAIL %s latency: toggled=%0b edges=%0d expected edges=%0d", tag, toggled, n, expN);
      end
      checks++;
      if (busyCnt !== (w2 ? 3 : 2)) begin
         errors++;
         $display("FAIL %s busy cycles: got %0d expected %0d", tag, busyCnt, w2 ? 3 : 2);
      end
      checks++;
      if (pcCnt !== expPc) begin
         errors++;
         $display("FAIL %s pcWrite cycles: got %0d expected %0d", tag, pcCnt, expPc);
      end
      checks++;
      if (cpsrOut !== {modelFlags, 28'h0}) begin
         errors++;
         $display("FAIL %s cpsrOut: got %h expected %h", tag, cpsrOut, {modelFlags, 28'h0});
      end
      for (int i = 0; i < 16; i++) begin
         rdAddr1 = 4'(i);
         rdAddr2 = 4'(15 - i);
         #1;
         checks++;
         if (rdData1 !== model[i] || rdData2 !== model[15 - i]) begin
            errors++;
            $display("FAIL %s reg r%0d/r%0d: got %h/%h expected %h/%h", tag, i, 15 - i,
                     rdData1, rdData2, model[i], model[15 - i]);
         end
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 16; i++) model[i] = '0;
      modelFlags = '0;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (aluIf.triggerOut !== 1'b0 || busy !== 1'b0 || pcWrite !== 1'b0 || timeoutErr !== 1'b0) begin
         errors++;
         $display("FAIL reset outputs: trig=%b busy=%b pc=%b tmo=%b expected all 0",
                  aluIf.triggerOut, busy, pcWrite, timeoutErr);
      end
      checks++;
      if (cpsrOut !== 32'h0) begin
         errors++;
         $display("FAIL reset cpsrOut: got %h expected 0", cpsrOut);
      end
      for (int i = 0; i < 16; i++) begin
         rdAddr1 = 4'(i);
         #1;
         checks++;
         if (rdData1 !== 32'h0) begin
            errors++;
            $display("FAIL reset reg r%0d: got %h expected 0", i, rdData1);
         end
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (aluIf.triggerOut !== 1'b1) begin
         errors++;
         $display("FAIL kick toggle: got %b expected 1", aluIf.triggerOut);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL busy after kick: got %b expected 0", busy);
      end
   endtask

   task automatic test_basic();
      run_txn(32'hDEADBEEF, 32'h0, 32'h6000_0000, 32'h0000_0003, 1'b1, "basic");
      run_txn(32'h1234_5678, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0007, 1'b0, "cmp");
   endtask

   task automatic test_dual_write();
      run_txn(32'h11, 32'h22, 32'h1000_0000, 32'h0000_0111, 1'b1, "dual_same");
      run_txn(32'hA5A5_0001, 32'h5A5A_0002, 32'h2000_0000, 32'hFFFF_F1A2, 1'b1, "dual_diff");
   endtask

   task automatic test_pc_write();
      run_txn(32'h100, 32'h0, 32'h0, 32'h0000_000F, 1'b1, "pc_single");
      run_txn(32'h200, 32'h300, 32'hF000_0000, 32'h0000_01FF, 1'b1, "pc_dual");
      run_txn(32'h0, 32'h400, 32'h0, 32'h0000_01F2, 1'b0, "pc_w2_only");
   endtask

   task automatic test_random();
      for (int t = 0; t < 24; t++) begin
         run_txn($urandom, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)), "random");
      end
   endtask

   task automatic test_timeout_reset();
      logic trig0;
      trig0 = aluIf.triggerOut;
      repeat (200) @(negedge clk);
      checks++;
      if (timeoutErr !== 1'b0) begin
         errors++;
         $display("FAIL early timeout: got %b expected 0", timeoutErr);
      end
      repeat (100) @(negedge clk);
      checks++;
      if (timeoutErr !== 1'b1) begin
         errors++;
         $display("FAIL timeout flag: got %b expected 1", timeoutErr);
      end
      checks++;
      if (aluIf.triggerOut !== trig0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout no-capture: trig=%b busy=%b expected trig=%b busy=0",
                  aluIf.triggerOut, busy, trig0);
      end
      // Next transaction, interrupted by reset while its second write is pending
      aluIf.readyIn  = 1'b0;
      aluIf.dataIn1  = 32'hCAFE_0005;
      aluIf.dataIn2  = 32'hCAFE_000F;
      aluIf.cpsrIn   = 32'h4000_0000;
      aluIf.srcDstIn = 32'h0000_01F5;
      aluIf.wIn      = 1'b1;
      repeat (3) @(negedge clk);
      aluIf.readyIn = 1'b1;
      repeat (SyncStages + 2) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy before reset: got %b expected 1", busy);
      end
      #2;
      reset         = 1'b0;
      aluIf.readyIn = 1'b0;
      #1;
      for (int i = 0; i < 16; i++) model[i] = '0;
      modelFlags = '0;
      for (int i = 0; i < 16; i++) begin
         rdAddr1 = 4'(i);
         #0.1;
         checks++;
         if (rdData1 !== 32'h0) begin
            errors++;
            $display("FAIL midreset reg r%0d: got %h expected 0", i, rdData1);
         end
      end
      checks++;
      if (timeoutErr !== 1'b0 || aluIf.triggerOut !== 1'b0 || cpsrOut !== 32'h0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL midreset outputs: tmo=%b trig=%b cpsr=%h busy=%b expected 0/0/0/0",
                  timeoutErr, aluIf.triggerOut, cpsrOut, busy);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (aluIf.triggerOut !== 1'b1) begin
         errors++;
         $display("FAIL kick after midreset: got %b expected 1", aluIf.triggerOut);
      end
      run_txn(32'h0BAD_F00D, 32'h0, 32'h3000_0000, 32'h0000_0009, 1'b1, "post_reset");
   endtask

   initial begin
      aluIf.readyIn  = 1'b0;
      aluIf.dataIn1  = '0;
      aluIf.dataIn2  = '0;
      aluIf.cpsrIn   = '0;
      aluIf.srcDstIn = '0;
      aluIf.wIn      = 1'b0;
      rdAddr1        = '0;
      rdAddr2        = '0;
      test_reset();
      test_basic();
      test_dual_write();
      test_pc_write();
      test_random();
      test_timeout_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
